// File: rtl/note_keys_ps2_tx_pkg.sv
// Shared definitions for the note-keyboard PS/2 emulator.
// Holds the eight note scan codes, the break prefix, the transmit FSM state
// enum and two small helpers used by the change detector.
package ps2_pkg;

  localparam logic [7:0] CODE_DO1   = 8'h16;
  localparam logic [7:0] CODE_RE    = 8'h1E;
  localparam logic [7:0] CODE_MI    = 8'h26;
  localparam logic [7:0] CODE_FA    = 8'h25;
  localparam logic [7:0] CODE_SO    = 8'h2E;
  localparam logic [7:0] CODE_LA    = 8'h36;
  localparam logic [7:0] CODE_SI    = 8'h3D;
  localparam logic [7:0] CODE_DO2   = 8'h3E;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } tx_state_e;

  function automatic logic [7:0] note_code(input logic [2:0] idx);
    logic [7:0] code;
    case (idx)
      3'd0:    code = CODE_DO1;
      3'd1:    code = CODE_RE;
      3'd2:    code = CODE_MI;
      3'd3:    code = CODE_FA;
      3'd4:    code = CODE_SO;
      3'd5:    code = CODE_LA;
      3'd6:    code = CODE_SI;
      default: code = CODE_DO2;
    endcase
    return code;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set (caller gates on diff != 0).
  function automatic logic [2:0] lowest_diff(input logic [7:0] diff);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (diff[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/note_keys_ps2_tx_if.sv
// Bundle of the emulator's key input, PS/2 line outputs and transmit status.
//   key_state : note-key bitmask into the emulator (1 = pressed)
//   ps2_clk   : PS/2 clock line, idle 1
//   ps2_data  : PS/2 data line, idle 1
//   busy      : a scan-code sequence is in progress
//   tx_byte   : byte currently or most recently sent
//   tx_done   : one-cycle pulse per completed byte
// master = emulator side, slave = consumer/driver side.
interface note_keys_ps2_tx_if;
  logic [7:0] key_state;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] tx_byte;
  logic       tx_done;

  modport master (
    input  key_state,
    output ps2_clk, ps2_data, busy, tx_byte, tx_done
  );

  modport slave (
    output key_state,
    input  ps2_clk, ps2_data, busy, tx_byte, tx_done
  );
endinterface

// File: rtl/note_keys_ps2_tx_frame_tx.sv
// PS/2 device-side byte serializer.
// Sends one 11-bit frame (start 0, data LSB first, odd parity, stop 1).
// Each bit cell is 2*CLK_DIV cycles: data changes at the cell start with the
// clock high for CLK_DIV cycles, then the clock is low for CLK_DIV cycles.
//   clk, clrn : system clock, async active-low reset
//   start     : one-cycle request, sampled only while idle
//   byte_in   : byte to send, captured with start
//   done      : combinational strobe, high on the cycle the stop cell ends
//   ps2_clk   : registered PS/2 clock line, idle 1
//   ps2_data  : registered PS/2 data line, idle 1
module ps2_frame_tx #(
  parameter int CLK_DIV = 2500
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active;
  logic          phase_low;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_idx;
  logic [10:0]   shreg;
  logic          div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign done    = active && phase_low && div_end && (bit_idx == 4'd10);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      active    <= 1'b0;
      phase_low <= 1'b0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '1;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active    <= 1'b1;
        phase_low <= 1'b0;
        div_cnt   <= '0;
        bit_idx   <= '0;
        shreg     <= {1'b1, ~^byte_in, byte_in, 1'b0};
        ps2_clk   <= 1'b1;
        ps2_data  <= 1'b0;
      end
    end else if (!div_end) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
      if (!phase_low) begin
        phase_low <= 1'b1;
        ps2_clk   <= 1'b0;
      end else begin
        phase_low <= 1'b0;
        ps2_clk   <= 1'b1;
        if (bit_idx == 4'd10) begin
          active   <= 1'b0;
          ps2_data <= 1'b1;
        end else begin
          bit_idx  <= bit_idx + 1'b1;
          shreg    <= {1'b1, shreg[10:1]};
          ps2_data <= shreg[1];
        end
      end
    end
  end

endmodule

// File: rtl/note_keys_ps2_tx.sv
// Device-side PS/2 keyboard emulator for the eight-note keyboard.
// Detects key transitions against last_state and sends a make code on press
// or F0 + code on release, one changed key per sequence, lowest index first.
//   clk  : system clock
//   clrn : async active-low reset
//   bus  : note_keys_ps2_tx_if.master (key_state in; ps2_clk, ps2_data,
//          busy, tx_byte, tx_done out)
// CLK_DIV    : system clocks per PS/2 clock half-period (>= 2)
// GAP_CYCLES : idle-high cycles after each byte's stop bit (>= 1)
module note_keys_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  clrn,
  note_keys_ps2_tx_if.master    bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_e     state;
  logic [7:0]    last_state;
  logic [7:0]    q0;
  logic [7:0]    q1;
  logic [1:0]    q_cnt;
  logic [GW-1:0] gap_cnt;
  logic          busy_r;
  logic [7:0]    tx_byte_r;
  logic          tx_done_r;
  logic          start_r;

  logic [7:0]    diff;
  logic [2:0]    idx;
  logic          frame_done;
  logic          line_clk;
  logic          line_data;

  assign diff = bus.key_state ^ last_state;
  assign idx  = lowest_diff(diff);

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start_r),
    .byte_in  (tx_byte_r),
    .done     (frame_done),
    .ps2_clk  (line_clk),
    .ps2_data (line_data)
  );

  assign bus.ps2_clk  = line_clk;
  assign bus.ps2_data = line_data;
  assign bus.busy     = busy_r;
  assign bus.tx_byte  = tx_byte_r;
  assign bus.tx_done  = tx_done_r;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      last_state <= '0;
      q0         <= '0;
      q1         <= '0;
      q_cnt      <= '0;
      gap_cnt    <= '0;
      busy_r     <= 1'b0;
      tx_byte_r  <= '0;
      tx_done_r  <= 1'b0;
      start_r    <= 1'b0;
    end else begin
      start_r   <= 1'b0;
      tx_done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (diff != '0) begin
            last_state[idx] <= bus.key_state[idx];
            if (bus.key_state[idx]) begin
              q0    <= note_code(idx);
              q_cnt <= 2'd1;
            end else begin
              q0    <= BREAK_CODE;
              q1    <= note_code(idx);
              q_cnt <= 2'd2;
            end
            busy_r <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // tx_byte_r doubles as the serializer's byte input; it is stable
          // by the time the registered start pulse reaches the serializer.
          tx_byte_r <= q0;
          q0        <= q1;
          q_cnt     <= q_cnt - 2'd1;
          start_r   <= 1'b1;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (frame_done) begin
            tx_done_r <= 1'b1;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (q_cnt != 2'd0) begin
              state <= ST_LOAD;
            end else begin
              busy_r <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_keys_ps2_tx.sv
module tb_note_keys_ps2_tx;

  logic clk;
  logic clrn;

  note_keys_ps2_tx_if bus_if ();

  note_keys_ps2_tx #(
    .CLK_DIV    (4),
    .GAP_CYCLES (20)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // frame monitor state (updated only from tick)
  logic       prev_clk;
  int         bitcnt;
  logic [10:0] sh;
  logic [7:0] got_q[$];
  int         done_cnt;

  typedef struct {
    logic [7:0]          key;
    int                  n;
    logic [0:15][7:0]    exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Advance to the next falling clk edge and decode any PS/2 clock fall.
  task automatic tick();
    @(negedge clk);
    if (!clrn) begin
      bitcnt   = 0;
      prev_clk = 1'b1;
    end else begin
      if (bus_if.tx_done) done_cnt++;
      if (prev_clk && !bus_if.ps2_clk) begin
        sh[bitcnt] = bus_if.ps2_data;
        bitcnt++;
        if (bitcnt == 11) begin
          check("frame_start", 32'(sh[0]), 32'd0);
          check("frame_parity", 32'(^sh[9:1]), 32'd1);
          check("frame_stop", 32'(sh[10]), 32'd1);
          got_q.push_back(sh[8:1]);
          bitcnt = 0;
        end
      end
      prev_clk = bus_if.ps2_clk;
    end
  endtask

  task automatic clear_capture();
    got_q.delete();
    done_cnt = 0;
  endtask

  // Wait until busy has stayed low for several cycles (sequence fully served).
  task automatic wait_quiet(input string name, input int budget);
    int quiet;
    int t;
    quiet = 0;
    t     = 0;
    while (quiet < 4 && t < budget) begin
      tick();
      t++;
      if (bus_if.busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int bad;
    checks   = 0;
    errors   = 0;
    prev_clk = 1'b1;
    bitcnt   = 0;
    sh       = '0;
    done_cnt = 0;
    clrn     = 1'b0;
    bus_if.key_state = 8'h00;

    vecs[0] = '{key: 8'h00, n: 2,  exp: {8'hF0, 8'h16, 112'h0}};
    vecs[1] = '{key: 8'h81, n: 2,  exp: {8'h16, 8'h3E, 112'h0}};
    vecs[2] = '{key: 8'h80, n: 2,  exp: {8'hF0, 8'h16, 112'h0}};
    vecs[3] = '{key: 8'hFF, n: 7,  exp: {8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 72'h0}};
    vecs[4] = '{key: 8'h7F, n: 2,  exp: {8'hF0, 8'h3E, 112'h0}};
    vecs[5] = '{key: 8'h00, n: 14, exp: {8'hF0, 8'h16, 8'hF0, 8'h1E, 8'hF0, 8'h26, 8'hF0, 8'h25,
                                        8'hF0, 8'h2E, 8'hF0, 8'h36, 8'hF0, 8'h3D, 16'h0}};

    // reset values
    repeat (3) tick();
    check("rst_ps2_clk", 32'(bus_if.ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(bus_if.ps2_data), 32'd1);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_tx_done", 32'(bus_if.tx_done), 32'd0);
    check("rst_tx_byte", 32'(bus_if.tx_byte), 32'h00);
    check("rst_last_state", 32'(dut.last_state), 32'h00);
    clrn = 1'b1;

    // idle with no keys for 1000 cycles
    bad = 0;
    clear_capture();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus_if.ps2_clk !== 1'b1 || bus_if.ps2_data !== 1'b1 || bus_if.busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 32'(bad), 32'd0);
    check("idle_tx_done", 32'(done_cnt), 32'd0);

    // first make 16: cycle-accurate timing, N = first rising edge after the change
    clear_capture();
    bus_if.key_state = 8'h01;
    for (int i = 1; i <= 115; i++) begin
      tick();
      if (i == 1)   check("t_busy_at_load", 32'(bus_if.busy), 32'd1);
      if (i == 1)   check("t_data_at_load", 32'(bus_if.ps2_data), 32'd1);
      if (i == 2)   check("t_tx_byte", 32'(bus_if.tx_byte), 32'h16);
      if (i == 2)   check("t_data_pre_start", 32'(bus_if.ps2_data), 32'd1);
      if (i == 3)   check("t_start_bit", 32'(bus_if.ps2_data), 32'd0);
      if (i == 3)   check("t_clk_high_cell0", 32'(bus_if.ps2_clk), 32'd1);
      if (i == 6)   check("t_clk_before_fall", 32'(bus_if.ps2_clk), 32'd1);
      if (i == 7)   check("t_clk_first_fall", 32'(bus_if.ps2_clk), 32'd0);
      if (i == 90)  check("t_done_early", 32'(bus_if.tx_done), 32'd0);
      if (i == 91)  check("t_done_pulse", 32'(bus_if.tx_done), 32'd1);
      if (i == 92)  check("t_done_width", 32'(bus_if.tx_done), 32'd0);
      if (i == 91)  check("t_gap_lines", 32'({bus_if.ps2_clk, bus_if.ps2_data}), 32'd3);
      if (i == 110) check("t_busy_last_gap", 32'(bus_if.busy), 32'd1);
      if (i == 111) check("t_busy_drop", 32'(bus_if.busy), 32'd0);
    end
    check("t_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t_byte", 32'(got_q[0]), 32'h16);
    check("t_done_cnt", 32'(done_cnt), 32'd1);
    check("t_last_state", 32'(dut.last_state), 32'h01);

    // table-driven key transitions
    for (int v = 0; v < 6; v++) begin
      clear_capture();
      bus_if.key_state = vecs[v].key;
      wait_quiet($sformatf("vec%0d", v), 4000);
      check($sformatf("vec%0d_nbytes", v), 32'(got_q.size()), 32'(vecs[v].n));
      for (int j = 0; j < vecs[v].n; j++) begin
        check($sformatf("vec%0d_byte%0d", v, j),
              (j < got_q.size()) ? 32'(got_q[j]) : 32'hDEAD, 32'(vecs[v].exp[j]));
      end
      check($sformatf("vec%0d_done_cnt", v), 32'(done_cnt), 32'(vecs[v].n));
      check($sformatf("vec%0d_last_state", v), 32'(dut.last_state), 32'(vecs[v].key));
    end

    // bit1 pulses while busy on make 16: must not produce any event
    clear_capture();
    bus_if.key_state = 8'h01;
    repeat (20) tick();
    bus_if.key_state = 8'h03;
    repeat (10) tick();
    bus_if.key_state = 8'h01;
    wait_quiet("glitch", 2000);
    check("glitch_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("glitch_byte", 32'(got_q[0]), 32'h16);
    check("glitch_last_state", 32'(dut.last_state), 32'h01);
    clear_capture();
    bus_if.key_state = 8'h00;
    wait_quiet("glitch_rel", 2000);
    check("glitch_rel_nbytes", 32'(got_q.size()), 32'd2);

    // reset mid-frame of 3E, key still held
    clear_capture();
    bus_if.key_state = 8'h80;
    bad = 0;
    while (!(bus_if.tx_byte == 8'h3E && bus_if.busy && bus_if.ps2_clk == 1'b0 && bitcnt >= 3) && bad < 500) begin
      tick();
      bad++;
    end
    check("mid_frame_reached", 32'(bad < 500), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    check("async_rst_clk", 32'(bus_if.ps2_clk), 32'd1);
    check("async_rst_data", 32'(bus_if.ps2_data), 32'd1);
    check("async_rst_busy", 32'(bus_if.busy), 32'd0);
    tick();
    tick();
    clrn = 1'b1;
    clear_capture();
    wait_quiet("rst_resend", 2000);
    check("resend_nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("resend_byte", 32'(got_q[0]), 32'h3E);
    check("resend_done_cnt", 32'(done_cnt), 32'd1);
    check("resend_last_state", 32'(dut.last_state), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_keys_ps2_tx.md
# note_keys_ps2_tx

Device-side PS/2 keyboard emulator for the eight-note keyboard. It watches an 8-bit note-key bitmask and converts each key transition into the scan-code byte stream a PS/2 keyboard would send: a make code on press, and `F0` plus the code on release. It drives open-drain-style `ps2_clk`/`ps2_data` lines, so note patterns can be played into the existing PS/2 receive and note-decode path for loopback tests and demos.

## Interface
- `CLK_DIV`, 2500: system clocks per PS/2 clock half-period (10 kHz at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, 5000: idle-high cycles after each byte's stop bit.
- `clk`  in  1  system clock; all logic on rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `key_state`  in  8  bitmask: bit0 DO_1 … bit7 DO_2; 1 = pressed.
- `ps2_clk`  out  1  PS/2 clock; idle 1.
- `ps2_data`  out  1  PS/2 data; idle 1.
- `busy`  out  1  high while a sequence is in progress.
- `tx_byte`  out  8  byte currently or most recently sent.
- `tx_done`  out  1  one-cycle pulse per completed byte.

## Operation
- Codes: bit0 16, bit1 1E, bit2 26, bit3 25, bit4 2E, bit5 36, bit6 3D, bit7 3E; break prefix F0.
- `last_state` register holds the key state last reported; it resets to 00.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE: if `key_state != last_state`, select the lowest index i where they differ.
  - Rising bit: queue 1 byte, code[i].
  - Falling bit: queue 2 bytes, F0 then code[i].
  - Set `last_state[i] <= key_state[i]` at this point. Go to LOAD.
- LOAD: present the next queued byte to the serializer, set `tx_byte`, go to SHIFT.
- SHIFT: send the 11-bit frame: start 0, data LSB first, odd parity, stop 1. On frame end go to GAP.
- GAP: hold both lines at 1 for GAP_CYCLES. Then go to LOAD if a byte is still queued, otherwise IDLE.
- Simultaneous changes: served one bit per sequence, lowest index first, re-evaluated at each return to IDLE.
- `key_state` is only compared in IDLE. A bit that changes and reverts while `busy` produces no event.
- The input is treated as synchronous to `clk`; no synchronizer is inside this block.

## Timing
- Bit cell is 2·CLK_DIV cycles:
  - `ps2_data` updates at the start of the cell, with `ps2_clk` = 1 for CLK_DIV cycles.
  - `ps2_clk` = 0 for the next CLK_DIV cycles; the host samples on the falling edge.
- Frame = 22·CLK_DIV cycles.
- A change sampled at edge N gives LOAD at N+1 and start bit on `ps2_data` from N+2. The first `ps2_clk` fall is at N+2+CLK_DIV.
- `tx_done` pulses for 1 cycle on the cycle the stop cell ends. GAP starts the same cycle.
- `busy` is 1 from LOAD through the last cycle of the final GAP of the sequence.
- Reset values:
  - `ps2_clk` = 1, `ps2_data` = 1.
  - `busy` = 0, `tx_done` = 0, `tx_byte` = 00.
  - `last_state` = 00, FSM in IDLE.
- Reset mid-frame: lines return to 1 immediately and the frame is aborted. After release, keys still held are re-reported as makes.

## Structure
- Shared package `ps2_pkg` holds:
  - the eight note scan-code constants;
  - the `F0` break constant;
  - the FSM state enum.
- Sub-module `ps2_frame_tx`: byte serializer with `start`/`byte_in`/`done`, owning the CLK_DIV divider, bit counter, parity and line outputs.
- Top level owns change detection, the byte queue (at most 2 deep) and the gap counter.

## Test plan
- Reset, `key_state` = 00 held 1000 cycles -> lines stay 1, `busy` = 0, no `tx_done`.
- CLK_DIV = 4, `key_state` 00→01 -> one 88-cycle frame, then one GAP.
  - Falling-edge samples: 0, 0,1,1,0,1,0,0,0, parity 0, stop 1.
  - `tx_byte` = 16, one `tx_done`.
- `key_state` 01→00 -> frame F0 (parity 1), gap, frame 16 (parity 0); two `tx_done`; `busy` drops after the second gap.
- `key_state` 00→81 in one cycle -> make 16, then make 3E, in that order; final `last_state` = 81.
- `clrn` pulsed low mid-frame of 3E with `key_state` = 80 -> lines go 1 asynchronously; after release a complete 3E frame is sent.
- While busy on make 16, bit1 is set for 10 cycles then cleared -> no 1E byte is ever emitted.
